// File: rtl/cwe1280_req_sequencer_if.sv
// Request/issue bundle for cwe1280_req_sequencer.
// Source side: req_valid/req_usr_id/req_data in, req_ready out.
// Issue side: registered out_usr_id/out_data/out_we toward the protected register,
// plus violation and lockout status.
interface cwe1280_req_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ID_W   = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   req_usr_id;
  logic [DATA_W-1:0] req_data;
  logic [ID_W-1:0]   out_usr_id;
  logic [DATA_W-1:0] out_data;
  logic              out_we;
  logic              viol_pulse;
  logic              lock_active;
  logic [7:0]        deny_total;

  // Request source and issue consumer (testbench / upstream logic)
  modport master (
    output req_valid, req_usr_id, req_data,
    input  req_ready, out_usr_id, out_data, out_we, viol_pulse, lock_active, deny_total
  );

  // The sequencer itself
  modport slave (
    input  req_valid, req_usr_id, req_data,
    output req_ready, out_usr_id, out_data, out_we, viol_pulse, lock_active, deny_total
  );
endinterface

// File: rtl/cwe1280_req_sequencer.sv
// cwe1280_req_sequencer
// Buffers usr_id-tagged write requests in a small FIFO and issues them paced, one per
// ISSUE_GAP cycles, toward the usr_id-gated protected register. Requester IDs other
// than AUTH_ID are counted as violations; LOCK_THRESH consecutive violations flush the
// FIFO and lock the source out for LOCK_CYCLES cycles.
// Build option: define CWE1280_SEQ_DROP_UNAUTH_EN to suppress forwarding of
// unauthorized requests (outputs stay idle); by default they are forwarded verbatim
// and the downstream gate rejects them. Violation accounting is identical either way.
module cwe1280_req_sequencer #(
  parameter int              DATA_W      = 8,
  parameter int              ID_W        = 3,
  parameter int              DEPTH       = 4,
  parameter logic [ID_W-1:0] AUTH_ID     = ID_W'(4),
  parameter logic [ID_W-1:0] IDLE_ID     = ID_W'(0),
  parameter int              ISSUE_GAP   = 2,
  parameter int              LOCK_THRESH = 3,
  parameter int              LOCK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  cwe1280_req_sequencer_if.slave  bus,
  output logic                    dbg_state   // 0 = RUN, 1 = LOCKED
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready are
  // both high. req_ready never looks at req_valid; once the source raises req_valid
  // it holds usr_id/data stable until the transfer edge.

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW  = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int CW  = $clog2(LOCK_THRESH + 1);
  localparam int EW  = ID_W + DATA_W;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t state_q, state_d;

  // FIFO storage, entry = {usr_id, data}
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          full, empty;

  // Pacing, violation and lockout counters
  logic [GW-1:0]  gap_q;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [CW-1:0]  consec_q, consec_d, consec_inc;
  logic [7:0]     deny_q;

  // Registered issue outputs
  logic [ID_W-1:0]   out_id_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_we_q;
  logic              viol_q;

  // Control strobes
  logic              push, pop, head_auth, unauth_pop, fwd, lock_trig;
  logic [ID_W-1:0]   head_id;
  logic [DATA_W-1:0] head_data;

  // Pointer-with-extra-bit full/empty: equal low bits, differing wrap bit = full
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign {head_id, head_data} = mem[rd_ptr_q[AW-1:0]];
  assign head_auth = (head_id == AUTH_ID);

  assign bus.req_ready = !full && (state_q == ST_RUN) && !rst;
  assign push          = bus.req_valid && bus.req_ready;
  // No bypass: only entries already stored before this edge can be popped
  assign pop           = (state_q == ST_RUN) && !empty && (gap_q == '0);
  assign unauth_pop    = pop && !head_auth;
  assign consec_inc    = consec_q + CW'(1);

`ifdef CWE1280_SEQ_DROP_UNAUTH_EN
  assign fwd = pop && head_auth;
`else
  assign fwd = pop;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      lock_cnt_q <= '0;
      consec_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      consec_q   <= consec_d;
    end
  end

  // FSM next state: violation streak tracking, lockout entry and countdown
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    consec_d   = consec_q;
    lock_trig  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (pop) begin
          if (head_auth) begin
            consec_d = '0;
          end else if (consec_inc == CW'(LOCK_THRESH)) begin
            consec_d   = '0;
            lock_trig  = 1'b1;
            state_d    = ST_LOCKED;
            lock_cnt_d = LCW'(LOCK_CYCLES - 1);
          end else begin
            consec_d = consec_inc;
          end
        end
      end
      ST_LOCKED: begin
        if (lock_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          lock_cnt_d = lock_cnt_q - LCW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FIFO storage write; stale contents are harmless because pointers gate reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= {bus.req_usr_id, bus.req_data};
    end
  end

  // FIFO pointers; a lockout entry discards everything, including a same-edge push
  always_ff @(posedge clk) begin
    if (rst || lock_trig) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Issue pacing: reload on every pop, otherwise count down to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else if (pop) begin
      gap_q <= GW'(ISSUE_GAP - 1);
    end else if (gap_q != '0) begin
      gap_q <= gap_q - GW'(1);
    end
  end

  // Issue outputs: idle pattern whenever nothing is forwarded, so AUTH_ID only
  // appears downstream on a real authorized issue
  always_ff @(posedge clk) begin
    if (rst) begin
      out_id_q   <= IDLE_ID;
      out_data_q <= '0;
      out_we_q   <= 1'b0;
    end else begin
      out_id_q   <= fwd ? head_id : IDLE_ID;
      out_data_q <= fwd ? head_data : '0;
      out_we_q   <= fwd;
    end
  end

  // Violation pulse and saturating denial count
  always_ff @(posedge clk) begin
    if (rst) begin
      viol_q <= 1'b0;
      deny_q <= '0;
    end else begin
      viol_q <= unauth_pop;
      if (unauth_pop && (deny_q != 8'hFF)) begin
        deny_q <= deny_q + 8'd1;
      end
    end
  end

  assign bus.out_usr_id  = out_id_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_we      = out_we_q;
  assign bus.viol_pulse  = viol_q;
  assign bus.lock_active = (state_q == ST_LOCKED);
  assign bus.deny_total  = deny_q;
  assign dbg_state       = state_q;

endmodule
